// File: rtl/demux16_wr_bank.sv
// demux16_wr_bank: write side of a 16-entry register bank.
// - Writes are accepted over a valid/ready handshake.
// - Each accepted write is decoded into a registered one-hot strobe.
// - The selected register takes the data one edge after acceptance.
// - A bulk-clear engine zeros the registers one per cycle through the
//   same strobe path.
// - An optional register can be hardwired to read as zero.
module demux16_wr_bank #(
   parameter int WIDTH    = 64,
   parameter bit ZERO_EN  = 1'b1,
   parameter int ZERO_IDX = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [3:0]            wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic [15:0]           wr_en_onehot,
   output logic [16*WIDTH-1:0]   q
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Registers that may actually be written; the hardwired-zero entry is masked out.
   localparam logic [15:0] WR_MASK = ZERO_EN ? ~(16'd1 << ZERO_IDX) : '1;

   function automatic logic [15:0] decode(input logic [3:0] a);
      return 16'd1 << a;
   endfunction

   state_t             state, next_state;
   logic [3:0]         cnt, next_cnt;
   logic [15:0]        next_onehot;
   logic [WIDTH-1:0]   s1_data, next_data;
   logic               next_done;
   logic [WIDTH-1:0]   regs [16];

   assign wr_ready = reset && (state == IDLE) && !clr_start;
   assign clr_busy = (state == CLEAR);

   // Next-state, clear sequencing and stage-1 capture of an accepted write.
   always_comb begin
      next_state  = state;
      next_cnt    = cnt;
      next_onehot = '0;
      next_data   = s1_data;
      next_done   = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) begin
               next_state = CLEAR;
               next_cnt   = '0;
            end else if (wr_valid) begin
               next_onehot = decode(wr_addr) & WR_MASK;
               next_data   = wr_data;
            end
         end
         CLEAR: begin
            next_onehot = decode(cnt);
            next_data   = '0;
            if (cnt == 4'd15) begin
               next_state = IDLE;
               next_cnt   = '0;
               next_done  = 1'b1;
            end else begin
               next_cnt = cnt + 4'd1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, stage-1 and register storage; reset discards any pending commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         wr_en_onehot <= '0;
         s1_data      <= '0;
         clr_done     <= 1'b0;
         for (int unsigned k = 0; k < 16; k++) begin
            regs[k] <= '0;
         end
      end else begin
         state        <= next_state;
         cnt          <= next_cnt;
         wr_en_onehot <= next_onehot;
         s1_data      <= next_data;
         clr_done     <= next_done;
         for (int unsigned k = 0; k < 16; k++) begin
            if (wr_en_onehot[k] && WR_MASK[k]) begin
               regs[k] <= s1_data;
            end
         end
      end
   end

   for (genvar k = 0; k < 16; k++) begin : g_q
      assign q[k*WIDTH +: WIDTH] = WR_MASK[k] ? regs[k] : '0;
   end

endmodule

// File: tb/tb_demux16_wr_bank.sv
// Self-checking bench for demux16_wr_bank (WIDTH=64, ZERO_EN=1, ZERO_IDX=15).
// A transaction-level model tracks the bank contents and the expected strobe.
module tb_demux16_wr_bank;

   localparam int W  = 64;
   localparam int ZI = 15;

   logic              clk;
   logic              reset;
   logic              wr_valid;
   logic              wr_ready;
   logic [3:0]        wr_addr;
   logic [W-1:0]      wr_data;
   logic              clr_start;
   logic              clr_busy;
   logic              clr_done;
   logic [15:0]       wr_en_onehot;
   logic [16*W-1:0]   q;

   demux16_wr_bank #(.WIDTH(W), .ZERO_EN(1'b1), .ZERO_IDX(ZI)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done), .wr_en_onehot(wr_en_onehot), .q(q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   logic [W-1:0] m_mem [16];
   logic         m_pv;
   logic [3:0]   m_pa;
   logic [W-1:0] m_pd;
   logic [15:0]  m_oh;
   logic         m_busy;
   logic         m_done;
   int           m_idx;
   logic         m_acc;

   // Advance one clock edge and update the model from the inputs seen at that edge.
   task automatic tick();
      @(posedge clk);
      m_acc  = 1'b0;
      m_done = 1'b0;
      if (!reset) begin
         for (int k = 0; k < 16; k++) m_mem[k] = '0;
         m_pv = 1'b0; m_oh = '0; m_busy = 1'b0; m_idx = 0;
      end else begin
         if (m_pv && m_pa != 4'(ZI)) m_mem[m_pa] = m_pd;
         if (m_busy) begin
            m_pv = 1'b1; m_pa = 4'(m_idx); m_pd = '0; m_oh = 16'd1 << m_idx;
            if (m_idx == 15) begin
               m_busy = 1'b0; m_done = 1'b1; m_idx = 0;
            end else begin
               m_idx++;
            end
         end else if (clr_start) begin
            m_busy = 1'b1; m_idx = 0; m_pv = 1'b0; m_oh = '0;
         end else if (wr_valid) begin
            m_acc = 1'b1; m_pv = 1'b1; m_pa = wr_addr; m_pd = wr_data;
            m_oh = (wr_addr == 4'(ZI)) ? 16'd0 : (16'd1 << wr_addr);
         end else begin
            m_pv = 1'b0; m_oh = '0;
         end
      end
      #1;
   endtask

   function automatic logic [16*W-1:0] model_q();
      logic [16*W-1:0] r;
      for (int k = 0; k < 16; k++) r[k*W +: W] = m_mem[k];
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0;
      tick(); tick();
      vectors++;
      if (wr_en_onehot !== 16'd0) begin errors++; $display("FAIL reset_onehot got %h exp 0000", wr_en_onehot); end
      vectors++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr got busy=%b done=%b exp 0 0", clr_busy, clr_done); end
      vectors++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b exp 0", wr_ready); end
      vectors++;
      if (q !== '0) begin errors++; $display("FAIL reset_q got nonzero exp all zero"); end
      reset = 1'b1; #1;
      vectors++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high got %b exp 1", wr_ready); end
   endtask

   task automatic test_single_write();
      wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 64'hDEAD_BEEF; #1;
      vectors++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", wr_ready); end
      tick();
      wr_valid = 1'b0;
      vectors++;
      if (wr_en_onehot !== 16'h0008) begin errors++; $display("FAIL single_onehot got %h exp 0008", wr_en_onehot); end
      vectors++;
      if (q[3*W +: W] !== '0) begin errors++; $display("FAIL single_early got %h exp 0", q[3*W +: W]); end
      tick();
      vectors++;
      if (q[3*W +: W] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_commit got %h exp deadbeef", q[3*W +: W]); end
      vectors++;
      if (q !== model_q()) begin errors++; $display("FAIL single_others got mismatching bank"); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_oh;
      for (int k = 0; k < 16; k++) begin
         wr_valid = 1'b1; wr_addr = 4'(k); wr_data = 64'(k + 'h100);
         tick();
         exp_oh = (k < 15) ? (16'd1 << k) : 16'd0;
         vectors++;
         if (wr_en_onehot !== exp_oh) begin errors++; $display("FAIL b2b_onehot[%0d] got %h exp %h", k, wr_en_onehot, exp_oh); end
      end
      wr_valid = 1'b0;
      tick(); tick();
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if (q[k*W +: W] !== ((k < 15) ? 64'(k + 'h100) : 64'd0)) begin
            errors++; $display("FAIL b2b_q[%0d] got %h exp %h", k, q[k*W +: W], (k < 15) ? 64'(k + 'h100) : 64'd0);
         end
      end
   endtask

   task automatic test_collision();
      wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 64'hA; tick();
      wr_data = 64'hB; tick();
      wr_valid = 1'b0;
      vectors++;
      if (q[7*W +: W] !== 64'hA) begin errors++; $display("FAIL coll_first got %h exp a", q[7*W +: W]); end
      tick();
      vectors++;
      if (q[7*W +: W] !== 64'hB) begin errors++; $display("FAIL coll_last got %h exp b", q[7*W +: W]); end
   endtask

   task automatic test_clear_contention();
      int busy_cnt;
      int done_cnt;
      int walk;
      for (int k = 0; k < 16; k++) begin
         wr_valid = 1'b1; wr_addr = 4'(k); wr_data = 64'hFF; tick();
      end
      wr_valid = 1'b0; tick(); tick();
      clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 64'd5; #1;
      vectors++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL contend_ready got %b exp 0", wr_ready); end
      tick();
      clr_start = 1'b0;
      busy_cnt = 0; done_cnt = 0; walk = 0;
      for (int c = 0; c < 22; c++) begin
         if (clr_busy) busy_cnt++;
         if (clr_done) begin
            done_cnt++;
            vectors++;
            if (q !== '0) begin errors++; $display("FAIL contend_cleared got nonzero exp all zero"); end
         end
         if (clr_busy && c > 0) begin
            vectors++;
            if (wr_en_onehot !== (16'd1 << walk)) begin errors++; $display("FAIL contend_walk[%0d] got %h exp %h", walk, wr_en_onehot, 16'd1 << walk); end
            walk++;
         end
         vectors++;
         if (wr_en_onehot !== m_oh) begin errors++; $display("FAIL contend_onehot[%0d] got %h exp %h", c, wr_en_onehot, m_oh); end
         tick();
         if (m_acc) wr_valid = 1'b0;
      end
      vectors++;
      if (busy_cnt !== 16) begin errors++; $display("FAIL contend_busy_cycles got %0d exp 16", busy_cnt); end
      vectors++;
      if (done_cnt !== 1) begin errors++; $display("FAIL contend_done_pulses got %0d exp 1", done_cnt); end
      vectors++;
      if (q[2*W +: W] !== 64'd5 || q !== model_q()) begin errors++; $display("FAIL contend_held_write got %h exp 5", q[2*W +: W]); end
   endtask

   task automatic test_pending_clear();
      int guard;
      wr_valid = 1'b1; wr_addr = 4'd4; wr_data = 64'd9; tick();
      wr_valid = 1'b0; clr_start = 1'b1; tick();
      clr_start = 1'b0;
      vectors++;
      if (q[4*W +: W] !== 64'd9) begin errors++; $display("FAIL pend_commit got %h exp 9", q[4*W +: W]); end
      vectors++;
      if (clr_busy !== 1'b1) begin errors++; $display("FAIL pend_busy got %b exp 1", clr_busy); end
      guard = 0;
      while (!m_done && guard < 30) begin tick(); guard++; end
      vectors++;
      if (clr_done !== 1'b1) begin errors++; $display("FAIL pend_done got %b exp 1 (waited %0d)", clr_done, guard); end
      tick();
      vectors++;
      if (q[4*W +: W] !== 64'd0 || q !== '0) begin errors++; $display("FAIL pend_cleared got %h exp 0", q[4*W +: W]); end
   endtask

   task automatic test_reset_mid_clear();
      for (int k = 0; k < 16; k++) begin
         wr_valid = 1'b1; wr_addr = 4'(k); wr_data = {$urandom, $urandom}; tick();
      end
      wr_valid = 1'b0; tick();
      clr_start = 1'b1; tick();
      clr_start = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      reset = 1'b0; tick();
      vectors++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL midclr_flags got busy=%b done=%b exp 0 0", clr_busy, clr_done); end
      vectors++;
      if (wr_en_onehot !== 16'd0) begin errors++; $display("FAIL midclr_onehot got %h exp 0000", wr_en_onehot); end
      vectors++;
      if (q !== '0) begin errors++; $display("FAIL midclr_q got nonzero exp all zero"); end
      reset = 1'b1; #1;
      vectors++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL midclr_ready got %b exp 1", wr_ready); end
   endtask

   task automatic test_random();
      logic exp_ready;
      for (int c = 0; c < 400; c++) begin
         if (!wr_valid || m_acc) begin
            wr_valid = ($urandom_range(3, 0) != 0);
            wr_addr  = 4'($urandom_range(15, 0));
            wr_data  = {$urandom, $urandom};
         end
         clr_start = ($urandom_range(24, 0) == 0);
         #1;
         exp_ready = !m_busy && !clr_start;
         vectors++;
         if (wr_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", c, wr_ready, exp_ready); end
         tick();
         vectors++;
         if (wr_en_onehot !== m_oh) begin errors++; $display("FAIL rand_onehot[%0d] got %h exp %h", c, wr_en_onehot, m_oh); end
         vectors++;
         if (clr_busy !== m_busy || clr_done !== m_done) begin
            errors++; $display("FAIL rand_clr[%0d] got busy=%b done=%b exp %b %b", c, clr_busy, clr_done, m_busy, m_done);
         end
         vectors++;
         if (q !== model_q()) begin errors++; $display("FAIL rand_q[%0d] got bank differs from model", c); end
      end
      wr_valid = 1'b0; clr_start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_collision();
      test_clear_contention();
      test_pending_clear();
      test_reset_mid_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/demux16_wr_bank.md
Name: demux16_wr_bank

Overview:
- Write side of the 16-entry register bank; the 16:1 read muxes select from the storage this block owns.
- Accepts one write per cycle over a valid/ready handshake and decodes the 4-bit address into a one-hot write strobe.
- The write data lands in the selected register one cycle after acceptance.
- Includes a sequenced bulk-clear engine that zeros the registers one per cycle through the same decoded strobe path, and an optional hardwired-zero register.

Parameters:
WIDTH, 64, data width of each register
ZERO_EN, 1, 1 = register ZERO_IDX reads 0 and ignores writes; 0 = all 16 writable
ZERO_IDX, 15, index of the hardwired-zero register (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset
wr_valid  input  1  write request present
wr_ready  output  1  bank can accept a write this cycle (combinational)
wr_addr  input  4  destination register index
wr_data  input  WIDTH  write data
clr_start  input  1  request bulk clear of all 16 registers
clr_busy  output  1  clear sequence in progress (registered)
clr_done  output  1  one-cycle pulse after the final clear write
wr_en_onehot  output  16  registered decoded strobe of the write being committed this cycle
q  output  16*WIDTH  flattened register contents; q[k*WIDTH +: WIDTH] = register k

Behaviour:
- Reset is synchronous, active-low (reset==0 at a rising edge):
  - all registers 0, state IDLE, stage-1 invalid, clear counter 0;
  - wr_en_onehot=0, clr_busy=0, clr_done=0.
- Reset asserted mid-write or mid-clear aborts everything; no partial commit happens at the reset edge.
- wr_ready = reset && state==IDLE && !clr_start.
- A write is accepted at an edge where wr_valid && wr_ready. Senders hold wr_addr and wr_data stable while wr_valid && !wr_ready.
- Pipeline:
  - Acceptance edge N: stage-1 captures addr and data and becomes valid; wr_en_onehot becomes decode(addr).
  - During cycle N..N+1 the stage-1 write commits; at edge N+1 the register updates.
  - New q is visible after edge N+1 (latency 2 edges from presentation). Throughput is 1 write/cycle; back-to-back writes are allowed.
  - Stage-1 is invalid at edge N+1 unless a new write was accepted.
- Zero register (ZERO_EN=1): a write to ZERO_IDX is accepted normally (handshake completes) but commits nothing. wr_en_onehot stays 0 for it, and q for ZERO_IDX is always 0.
- Same address written twice back-to-back: the later write wins. Commits occur in acceptance order.
- FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR at an edge where clr_start==1. No write is accepted at that edge. Counter is set to 0 and clr_busy becomes 1.
  - A stage-1 write pending at that edge still commits at that edge.
  - In CLEAR, each cycle: wr_en_onehot = decode(counter) registered as for writes; register[counter] <= 0 at the next edge; counter increments.
  - Clearing ZERO_IDX is harmless.
  - After the edge that clears index 15: state returns to IDLE, clr_busy=0, clr_done=1 for exactly one cycle.
  - A clear takes 16 cycles in CLEAR, so wr_ready is low for 17 cycles including the clr_start cycle.
- clr_start while already in CLEAR is ignored; the counter is not restarted.
- clr_start and wr_valid in the same IDLE cycle: clear wins and the write is not accepted (wr_ready=0). The sender keeps wr_valid asserted.
- Counter is 4 bits, with no wrap past 15: exit happens on 15.
- wr_en_onehot is never more than one bit hot. It is 0 on any cycle with nothing to commit.

Test Plan:
- Reset then single write: write addr=3 data=0xDEAD_BEEF -> wr_ready=1; next cycle wr_en_onehot=0x0008; register 3 = 0xDEADBEEF one edge later; all other registers remain 0.
- Back-to-back sweep: write addr k with data k+0x100 on 16 consecutive cycles -> wr_en_onehot walks 0x0001..0x4000 and is 0 for addr 15; final q[k]=k+0x100 for k<15, q[15]=0 (ZERO_EN=1).
- Same-address collision: addr=7 data=0xA, then addr=7 data=0xB on the next cycle -> register 7 = 0xB.
- Clear contention: fill all registers with 0xFF; assert clr_start and wr_valid(addr 2, data 5) in the same cycle -> write refused; clr_busy high 16 cycles; wr_en_onehot walks 0x0001..0x8000; clr_done pulses once; all q=0; the held write is then accepted and register 2 = 5.
- Pending write at clear start: accept addr=4 data=9, assert clr_start the next cycle -> register 4 is briefly 9, then 0 after the clear completes.
- Reset mid-clear: drop reset at clear counter=6 -> at the next edge clr_busy=0, clr_done=0, wr_en_onehot=0, all q=0, state IDLE, wr_ready=1 once reset is released.
